// File: rtl/sram_port_arbiter.sv
// Arbitrates one SRAM-like memory port between the fetch (inst) and data requesters.
// Data wins by default; a grant streak counter forces a fetch grant after STARVE_LIMIT data grants.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_cancel,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state, state_n;
    logic                owner, owner_n;   // 0 = inst, 1 = data
    logic                drop, drop_n;
    logic [STREAK_W-1:0] streak, streak_n;

    logic                sel_valid;
    logic                sel_data;

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            owner  <= 1'b0;
            drop   <= 1'b0;
            streak <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            drop   <= drop_n;
            streak <= streak_n;
        end
    end

    // Grant selection, response routing and next-state logic
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        drop_n       = drop;
        streak_n     = streak;
        sel_valid    = 1'b0;
        sel_data     = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                if (data_req && !(inst_req && (streak == STREAK_MAX))) begin
                    sel_valid = 1'b1;
                    sel_data  = 1'b1;
                end else if (inst_req) begin
                    sel_valid = 1'b1;
                end

                mem_req = sel_valid;
                if (sel_valid && sel_data) begin
                    mem_wr       = data_wr;
                    mem_size     = data_size;
                    mem_addr     = data_addr;
                    mem_wdata    = data_wdata;
                    data_addr_ok = mem_addr_ok;
                end else if (sel_valid) begin
                    mem_size     = SIZE_WORD;
                    mem_addr     = inst_addr;
                    inst_addr_ok = mem_addr_ok;
                end

                if (sel_valid && mem_addr_ok) begin
                    state_n = WAIT;
                    owner_n = sel_data;
                    drop_n  = !sel_data && inst_cancel;
                    // Streak counts data grants made while a fetch is waiting
                    if (sel_data && inst_req) begin
                        if (streak != STREAK_MAX) begin
                            streak_n = streak + STREAK_W'(1);
                        end
                    end else begin
                        streak_n = '0;
                    end
                end
            end

            WAIT: begin
                busy = 1'b1;
                if (!owner && inst_cancel) begin
                    drop_n = 1'b1;
                end
                if (mem_data_ok) begin
                    if (owner) begin
                        data_data_ok = 1'b1;
                        data_rdata   = mem_rdata;
                    end else if (!(drop || inst_cancel)) begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = mem_rdata;
                    end
                    state_n = IDLE;
                    drop_n  = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Hold every output low while reset is asserted
        if (!resetn) begin
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = '0;
            mem_req      = 1'b0;
            mem_wr       = 1'b0;
            mem_size     = 2'd0;
            mem_addr     = '0;
            mem_wdata    = '0;
            busy         = 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with hand-computed expectations.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_cancel;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    sram_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_cancel  (inst_cancel),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        string order;
        string expect_order;
        resetn      = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0000;
        inst_cancel = 1'b0;
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_size   = 2'd2;
        data_addr   = 32'h1c01_0000;
        data_wdata  = 32'hdead_beef;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h5555_aaaa;

        // Reset: outputs forced low even with requests present
        #2;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        #10 resetn = 1'b1;

        // Single fetch
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
        #1;
        chk("f_addr_ok", 64'(inst_addr_ok), 64'd1);
        chk("f_mem_addr", 64'(mem_addr), 64'h1c00_0000);
        chk("f_mem_wr_size", 64'({mem_wr, mem_size}), 64'd2);
        chk("f_busy0", 64'(busy), 64'd0);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        chk("f_busy1", 64'(busy), 64'd1);
        chk("f_no_data1", 64'(inst_data_ok), 64'd0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0c0c;
        #1;
        chk("f_busy2", 64'(busy), 64'd1);
        chk("f_data_ok", 64'(inst_data_ok), 64'd1);
        chk("f_rdata", 64'(inst_rdata), 64'h0280_0c0c);
        chk("f_d_side_quiet", 64'({data_data_ok, data_rdata}), 64'd0);
        tick();
        mem_data_ok = 1'b0;
        #1;
        chk("f_idle", 64'(busy), 64'd0);

        // Simultaneous requests: data write goes first
        inst_req = 1'b1; inst_addr = 32'h1c00_0004;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h1c01_0000; data_wdata = 32'hdead_beef;
        mem_addr_ok = 1'b1;
        #1;
        chk("s_mem_wr", 64'(mem_wr), 64'd1);
        chk("s_mem_addr", 64'(mem_addr), 64'h1c01_0000);
        chk("s_mem_wdata", 64'(mem_wdata), 64'hdead_beef);
        chk("s_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
        chk("s_data_addr_ok", 64'(data_addr_ok), 64'd1);
        tick();
        data_req = 1'b0;
        #1;
        chk("s_wait_no_req", 64'({mem_req, inst_addr_ok}), 64'd0);
        mem_data_ok = 1'b1; mem_rdata = 32'h0;
        #1;
        chk("s_wr_done", 64'(data_data_ok), 64'd1);
        chk("s_no_regrant", 64'(mem_req), 64'd0);
        tick();
        mem_data_ok = 1'b0;
        #1;
        chk("s_inst_grant", 64'(inst_addr_ok), 64'd1);
        chk("s_inst_addr", 64'(mem_addr), 64'h1c00_0004);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        chk("s_inst_data", 64'({inst_data_ok, inst_rdata}), 64'h1_1111_2222);
        tick();
        mem_data_ok = 1'b0;

        // Starvation: both held high, limit 4
        inst_req = 1'b1; inst_addr = 32'h1c00_0008;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1c01_0010;
        order = "";
        expect_order = "DDDDIDDDDID";
        for (int i = 0; i < 11; i++) begin
            mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
            #1;
            order = {order, data_addr_ok ? "D" : (inst_addr_ok ? "I" : "-")};
            tick();
            mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'(i);
            #1;
            chk("st_resp", 64'({inst_data_ok, data_data_ok}),
                (expect_order[i] == "I") ? 64'd2 : 64'd1);
            tick();
        end
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("st_grant%0d", i), 64'(order[i]), 64'(expect_order[i]));
        end
        inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;

        // Cancel in WAIT drops the response
        inst_req = 1'b1; inst_addr = 32'h1c00_0100; mem_addr_ok = 1'b1;
        #1;
        chk("c_grant", 64'(inst_addr_ok), 64'd1);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; inst_cancel = 1'b1;
        tick();
        inst_cancel = 1'b0;
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("c_dropped", 64'({inst_data_ok, inst_rdata}), 64'd0);
        tick();
        mem_data_ok = 1'b0;
        #1;
        chk("c_idle", 64'(busy), 64'd0);
        inst_req = 1'b1; inst_addr = 32'h1c00_0104; mem_addr_ok = 1'b1;
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hcafe_f00d;
        #1;
        chk("c_next_fetch", 64'({inst_data_ok, inst_rdata}), 64'h1_cafe_f00d);
        tick();
        mem_data_ok = 1'b0;

        // Cancel in the grant cycle also drops the response
        inst_req = 1'b1; inst_cancel = 1'b1; mem_addr_ok = 1'b1;
        tick();
        inst_req = 1'b0; inst_cancel = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h0bad_0bad;
        #1;
        chk("c_grant_cancel", 64'(inst_data_ok), 64'd0);
        tick();
        mem_data_ok = 1'b0;

        // Asynchronous reset while in WAIT
        data_req = 1'b1; data_addr = 32'h1c01_0020; mem_addr_ok = 1'b1;
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        chk("r_busy_before", 64'(busy), 64'd1);
        inst_req = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
        resetn = 1'b0;
        #1;
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_outs", 64'({mem_req, data_data_ok, inst_addr_ok, mem_addr}), 64'd0);
        inst_req = 1'b0;
        #1 resetn = 1'b1;
        tick();
        #1;
        chk("r_stale_ignored", 64'({busy, data_data_ok, inst_data_ok, data_rdata}), 64'd0);
        tick();
        mem_data_ok = 1'b0;
        #1;
        chk("r_still_idle", 64'(busy), 64'd0);

        // Back-pressure: address held until memory accepts
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h1c02_0000;
        mem_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_req%0d", i), 64'({busy, mem_req, mem_addr}), 64'h1_1c02_0000);
            tick();
        end
        mem_addr_ok = 1'b1;
        #1;
        chk("bp_accept", 64'({data_addr_ok, mem_size}), 64'h4);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        chk("bp_wait", 64'(busy), 64'd1);
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_00a5;
        #1;
        chk("bp_rdata", 64'({data_data_ok, data_rdata}), 64'h1_0000_00a5);
        tick();
        mem_data_ok = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Sits between the pipeline and the single external memory interface.
- Data side has priority; a starvation counter guarantees fetch progress.
- Allows one outstanding transaction at a time. Discards instruction responses cancelled by a pipeline flush.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants allowed while an instruction request is waiting (1..15).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- inst_cancel  in  1  IF flush: drop any pending fetch response
- data_req  in  1  data request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data response (read data or write done)
- data_rdata  out  DATA_W  read data
- mem_req  out  1  to memory
- mem_wr  out  1  to memory
- mem_size  out  2  to memory
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_addr_ok  in  1  memory accepted the address
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  a transaction is outstanding

Behaviour:
- FSM states: IDLE, WAIT.
- Registers: owner (0 = inst, 1 = data), drop, streak counter.
- Reset (resetn = 0, asynchronous):
  - state = IDLE, owner = 0, drop = 0, streak = 0.
  - All outputs are forced to 0, including the combinational ones.
- Grant in IDLE (combinational):
  - sel = data when data_req && !(inst_req && streak == STARVE_LIMIT); otherwise sel = inst when inst_req.
  - mem_req = sel valid.
  - mem_* fields come from the selected master.
  - For inst: mem_wr = 0, mem_size = 2, mem_wdata = 0.
- Address ack: only the selected master sees X_addr_ok = mem_addr_ok. The non-selected master sees addr_ok = 0.
- IDLE -> WAIT on mem_req && mem_addr_ok:
  - Latch owner = sel.
  - drop = 1 if sel = inst and inst_cancel is high that cycle.
  - Streak: on a data grant with inst_req high, streak += 1 (saturates at STARVE_LIMIT). On an inst grant, streak = 0. On a data grant with inst_req low, streak = 0.
- In WAIT:
  - mem_req = 0 and all addr_ok = 0.
  - inst_cancel while owner = inst sets drop.
- On mem_data_ok in WAIT:
  - Route mem_rdata to the owner's rdata; the owner's data_ok = 1 for one cycle.
  - If owner = inst and (drop || inst_cancel), inst_data_ok stays 0.
  - Next state IDLE; drop cleared.
  - No new grant in that same cycle, so minimum spacing is 1 IDLE cycle.
- mem_data_ok in IDLE is ignored and not forwarded.
- rdata outputs are 0 whenever their data_ok is 0.
- busy = (state == WAIT).
- Minimum latency:
  - request to addr_ok: 0 cycles (combinational passthrough);
  - addr_ok to data_ok: equal to memory latency, at least 1 cycle.
- inst_cancel in IDLE has no effect, because no response is outstanding.

Test Plan:
- Single fetch:
  - Stimulus: inst_req = 1, addr 0x1c000000; memory addr_ok same cycle, data_ok 2 cycles later with 0x02800c0c.
  - Required: inst_addr_ok = 1 in cycle 0; inst_data_ok = 1 with rdata 0x02800c0c in cycle 2; busy high in cycles 1-2.
- Simultaneous requests:
  - Stimulus: inst_req and data_req both high, data write to 0x1c010000 with wdata 0xdeadbeef, size 2.
  - Required: mem_wr = 1 and mem_addr = 0x1c010000 granted first; inst_addr_ok = 0; the fetch is granted after the data response.
- Starvation:
  - Stimulus: data_req and inst_req held high, STARVE_LIMIT = 4.
  - Required: grant order D, D, D, D, I, D...; streak resets after the I grant.
- Cancel:
  - Stimulus: fetch granted; inst_cancel pulses in WAIT; mem_data_ok later with 0x12345678.
  - Required: inst_data_ok stays 0; FSM returns to IDLE; the next fetch completes normally.
- Reset mid-transaction:
  - Stimulus: resetn driven low asynchronously while in WAIT.
  - Required: all outputs are 0 immediately; after release, state is IDLE and a stale mem_data_ok is ignored.
- Back-pressure:
  - Stimulus: mem_addr_ok held 0 for 3 cycles with data_req high.
  - Required: stays in IDLE with mem_req = 1 and the address stable; transitions to WAIT only on the cycle mem_addr_ok = 1.
